ds_instr_queue: RTL and testbench

Dual-issue instruction queue between the instruction fetch stage and the decode/dispatch stage. Accepts up to two fetched (and already decompressed) instructions per cycle and stores them in a small in-order circular buffer. Presents the two oldest entries to decode, which retires zero, one or two of them per cycle. Its purpose is to decouple fetch from decode stalls and to break the combinational ready path from decode back into fetch; a redirect flushes all buffered entries.

---
 rtl/super_pkg.sv | 14 +
 rtl/ds_instr_queue.sv | 101 ++++++++++
 tb/tb_ds_instr_queue.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/super_pkg.sv
// Shared pipeline types and defaults for the fetch/decode front end.
package super_pkg;

  localparam int unsigned IQ_DEPTH_DEFAULT = 4;

  // Fetched, already-decompressed instruction as carried between stages.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_compressed;
    logic        fetch_err;
  } ir_reg_t;

endpackage

// File: rtl/ds_instr_queue.sv
// Dual-issue in-order instruction queue between fetch and decode.
// Ready and valid come only from the registered occupancy, so decode never loops back into fetch.
module ds_instr_queue
  import super_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic [1:0] if_valid_i,
  input  ir_reg_t    if_instr0_i,
  input  ir_reg_t    if_instr1_i,
  output logic [1:0] ds_rdy_o,
  output logic [1:0] id_valid_o,
  output ir_reg_t    id_instr0_o,
  output ir_reg_t    id_instr1_o,
  input  logic [1:0] id_accept_i,
  output logic       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  ir_reg_t mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_p1, rptr_p1;
  logic          push0, push1;
  logic [CW-1:0] push_cnt, pop_cnt;

  assign wptr_p1 = wptr_q + 1'b1;
  assign rptr_p1 = rptr_q + 1'b1;

  assign ds_rdy_o[0]   = (cnt_q <= CW'(DEPTH - 1));
  assign ds_rdy_o[1]   = (cnt_q <= CW'(DEPTH - 2));
  assign id_valid_o[0] = (cnt_q >= CW'(1));
  assign id_valid_o[1] = (cnt_q >= CW'(2));
  assign empty_o       = (cnt_q == '0);

  assign id_instr0_o = mem[rptr_q];
  assign id_instr1_o = mem[rptr_p1];

  // Slot 1 rides only behind slot 0 so fetch keeps program order.
  assign push0    = if_valid_i[0] & ds_rdy_o[0];
  assign push1    = if_valid_i[1] & ds_rdy_o[1] & push0;
  assign push_cnt = CW'(push0) + CW'(push1);
  assign pop_cnt  = CW'(id_accept_i[0]) + CW'(id_accept_i[1]);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      wptr_d = wptr_q + PW'(push_cnt);
      rptr_d = rptr_q + PW'(pop_cnt);
      cnt_d  = cnt_q + push_cnt - pop_cnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is deliberately left unreset; valid bits gate its visibility.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      if (push0) mem[wptr_q]  <= if_instr0_i;
      if (push1) mem[wptr_p1] <= if_instr1_i;
    end
  end

`ifndef SYNTHESIS
  a_if_valid_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    if_valid_i != 2'b10)
    else $error("ds_instr_queue: illegal if_valid_i=10");

  a_accept_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    id_accept_i != 2'b10)
    else $error("ds_instr_queue: illegal id_accept_i=10");

  a_accept_within_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop_cnt <= cnt_q)
    else $error("ds_instr_queue: accepted more entries than held");
`endif

endmodule

// File: tb/tb_ds_instr_queue.sv
// Directed plus randomized bench for ds_instr_queue against a queue-based reference model.
module tb_ds_instr_queue;
  import super_pkg::*;

  localparam int D = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0;
  logic [1:0] if_valid_i = 2'b00;
  logic [1:0] id_accept_i = 2'b00;
  ir_reg_t    if_instr0_i = '0;
  ir_reg_t    if_instr1_i = '0;
  logic [1:0] ds_rdy_o, id_valid_o;
  ir_reg_t    id_instr0_o, id_instr1_o;
  logic       empty_o;

  int checks = 0;
  int failures = 0;
  int taken = 0;
  ir_reg_t model_q[$];

  ds_instr_queue #(.DEPTH(D)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .if_valid_i  (if_valid_i),
    .if_instr0_i (if_instr0_i),
    .if_instr1_i (if_instr1_i),
    .ds_rdy_o    (ds_rdy_o),
    .id_valid_o  (id_valid_o),
    .id_instr0_o (id_instr0_o),
    .id_instr1_o (id_instr1_o),
    .id_accept_i (id_accept_i),
    .empty_o     (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Expected outputs follow directly from how many entries the model holds.
  task automatic check_outputs(input string ctx);
    int n;
    n = model_q.size();
    chk({ctx, ".id_valid"}, 128'(id_valid_o), 128'({n >= 2, n >= 1}));
    chk({ctx, ".ds_rdy"},   128'(ds_rdy_o),   128'({(D - n) >= 2, (D - n) >= 1}));
    chk({ctx, ".empty"},    128'(empty_o),    128'(n == 0));
    if (n >= 1) chk({ctx, ".instr0"}, 128'(id_instr0_o), 128'(model_q[0]));
    if (n >= 2) chk({ctx, ".instr1"}, 128'(id_instr1_o), 128'(model_q[1]));
  endtask

  function automatic ir_reg_t rnd_instr(input int unsigned pc);
    ir_reg_t r;
    r.pc            = pc;
    r.instr         = $urandom;
    r.is_compressed = 1'($urandom_range(0, 1));
    r.fetch_err     = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // One clock: drive at negedge, check pre-edge state, advance model at posedge.
  task automatic step(input logic [1:0] v, input ir_reg_t i0, input ir_reg_t i1,
                      input logic [1:0] acc, input logic fl, input string ctx);
    int n;
    int free;
    if_valid_i  = v;
    if_instr0_i = i0;
    if_instr1_i = i1;
    id_accept_i = acc;
    flush_i     = fl;
    #1;
    check_outputs(ctx);
    n    = model_q.size();
    free = D - n;
    @(posedge clk_i);
    taken = 0;
    if (fl) begin
      model_q.delete();
    end else begin
      repeat (int'(acc[0]) + int'(acc[1])) void'(model_q.pop_front());
      if (v[0] && free >= 1) begin
        model_q.push_back(i0);
        taken = 1;
        if (v[1] && free >= 2) begin
          model_q.push_back(i1);
          taken = 2;
        end
      end
    end
    @(negedge clk_i);
    if_valid_i  = 2'b00;
    id_accept_i = 2'b00;
    flush_i     = 1'b0;
  endtask

  initial begin
    ir_reg_t a, b, x, y;
    int unsigned next_seq;
    int unsigned next_acc;
    int n_acc;
    logic [1:0] v, acc;

    repeat (2) @(negedge clk_i);
    #1;
    check_outputs("in_reset");
    rst_ni = 1'b1;

    for (int i = 0; i < 10; i++) step(2'b00, '0, '0, 2'b00, 1'b0, "idle");

    a = rnd_instr(32'h100);
    b = rnd_instr(32'h104);
    step(2'b11, a, b, 2'b00, 1'b0, "push_ab");
    step(2'b11, rnd_instr(32'h108), rnd_instr(32'h10c), 2'b00, 1'b0, "cnt2");
    step(2'b11, rnd_instr(32'h110), rnd_instr(32'h114), 2'b00, 1'b0, "full");
    chk("full_rejects_push", 128'(taken), 128'(0));
    step(2'b00, '0, '0, 2'b01, 1'b0, "full_pop1");
    step(2'b11, rnd_instr(32'h118), rnd_instr(32'h11c), 2'b00, 1'b0, "one_free");
    chk("one_free_takes_one", 128'(taken), 128'(1));
    step(2'b00, '0, '0, 2'b00, 1'b1, "refill_full");

    // Randomized streaming: pcs carry a sequence number, decode must see them in order.
    next_seq = 0;
    next_acc = 0;
    step(2'b00, '0, '0, 2'b00, 1'b0, "stream_start");
    for (int c = 0; c < 60; c++) begin
      case ($urandom_range(0, 2))
        0:       v = 2'b00;
        1:       v = 2'b01;
        default: v = 2'b11;
      endcase
      n_acc = $urandom_range(0, (model_q.size() >= 2) ? 2 : model_q.size());
      if (c >= 50) n_acc = (model_q.size() >= 2) ? 2 : model_q.size();
      if (c >= 50) v = 2'b00;
      acc = (n_acc == 2) ? 2'b11 : (n_acc == 1) ? 2'b01 : 2'b00;
      if (n_acc >= 1) chk("stream_order0", 128'(id_instr0_o.pc), 128'(next_acc));
      if (n_acc >= 2) chk("stream_order1", 128'(id_instr1_o.pc), 128'(next_acc + 1));
      next_acc += n_acc;
      step(v, rnd_instr(next_seq), rnd_instr(next_seq + 1), acc, 1'b0, "stream");
      next_seq += taken;
    end
    chk("stream_drained", 128'(model_q.size()), 128'(0));
    chk("stream_count", 128'(next_acc), 128'(next_seq));

    step(2'b11, rnd_instr(32'h200), rnd_instr(32'h204), 2'b00, 1'b0, "sim_fill");
    x = rnd_instr(32'h208);
    y = rnd_instr(32'h20c);
    step(2'b11, x, y, 2'b11, 1'b0, "sim_push_pop");
    #1;
    chk("sim_instr0", 128'(id_instr0_o), 128'(x));
    chk("sim_instr1", 128'(id_instr1_o), 128'(y));
    step(2'b00, '0, '0, 2'b11, 1'b0, "sim_after");

    step(2'b11, rnd_instr(32'h300), rnd_instr(32'h304), 2'b00, 1'b0, "fl_fill2");
    step(2'b01, rnd_instr(32'h308), '0, 2'b00, 1'b0, "fl_fill3");
    step(2'b11, rnd_instr(32'h30c), rnd_instr(32'h310), 2'b01, 1'b1, "flush_cnt3");
    step(2'b00, '0, '0, 2'b00, 1'b0, "after_flush");
    step(2'b11, rnd_instr(32'h400), rnd_instr(32'h404), 2'b00, 1'b0, "post_flush_push");
    step(2'b00, '0, '0, 2'b00, 1'b0, "post_flush_view");

    // Asynchronous reset in the middle of a cycle, released together with a flush.
    #2;
    rst_ni = 1'b0;
    #1;
    model_q.delete();
    check_outputs("async_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(2'b11, rnd_instr(32'h500), rnd_instr(32'h504), 2'b00, 1'b1, "release_flush");
    step(2'b00, '0, '0, 2'b00, 1'b0, "after_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
